// File: rtl/mcp_pkg.sv
// Shared types and defaults for the multi-cycle-path CDC receive side.
package mcp_pkg;

  typedef enum logic {IDLE = 1'b0, VALID = 1'b1} mcp_rx_state_t;

  localparam int unsigned MCP_DEF_SYNC_STAGES = 2;
  localparam int unsigned MCP_DEF_DW          = 8;

endpackage

// File: rtl/b_sync_pulse.sv
// Level synchronizer for a toggle enable plus edge detector producing one
// b-domain pulse per level change in either direction.
module b_sync_pulse
  import mcp_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = MCP_DEF_SYNC_STAGES
) (
  input  logic bclk,
  input  logic brst,
  input  logic d,
  output logic pulse,
  output logic q
);

  logic [SYNC_STAGES-1:0] bq;
  logic                   bq_d;

  // Synchronizer chain and edge-detect delay flop
  always_ff @(posedge bclk) begin
    if (brst) begin
      bq   <= '0;
      bq_d <= 1'b0;
    end else begin
      bq   <= {bq[SYNC_STAGES-2:0], d};
      bq_d <= bq[SYNC_STAGES-1];
    end
  end

  assign q     = bq[SYNC_STAGES-1];
  assign pulse = q ^ bq_d;

endmodule

// File: rtl/b_mcp_receive.sv
// MCP receive end: syncs the sender's toggle enable, captures the held word,
// offers it with valid/load and returns a toggle ack once it is consumed.
module b_mcp_receive
  import mcp_pkg::*;
#(
  parameter int unsigned DW          = MCP_DEF_DW,
  parameter int unsigned SYNC_STAGES = MCP_DEF_SYNC_STAGES
) (
  input  logic          bclk,
  input  logic          brst,
  input  logic [DW-1:0] adata,
  input  logic          a_en,
  input  logic          bload,
  output logic [DW-1:0] bdata,
  output logic          bvalid,
  output logic          b_ack,
  output logic          berr
);

  mcp_rx_state_t state_q;
  mcp_rx_state_t state_d;
  logic          bpulse;
  logic          bq_lvl;
  logic          capture_c;
  logic          ack_tgl_c;
  logic          err_set_c;

  b_sync_pulse #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .bclk (bclk),
    .brst (brst),
    .d    (a_en),
    .pulse(bpulse),
    .q    (bq_lvl)
  );

  // A pulse must always correspond to a change of the synchronized level
  a_pulse_is_edge : assert property (@(posedge bclk) disable iff (brst)
    bpulse |-> (bq_lvl != $past(bq_lvl)));

  always_ff @(posedge bclk) begin
    if (brst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bpulse) state_d = VALID;
      VALID:   if (bload)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A pulse arriving while a word is still pending is a protocol violation and is dropped
  always_comb begin
    capture_c = 1'b0;
    ack_tgl_c = 1'b0;
    err_set_c = 1'b0;
    case (state_q)
      IDLE: begin
        capture_c = bpulse;
      end
      VALID: begin
        ack_tgl_c = bload;
        err_set_c = bpulse;
      end
      default: ;
    endcase
  end

  always_ff @(posedge bclk) begin
    if (brst) begin
      bdata <= '0;
      b_ack <= 1'b0;
      berr  <= 1'b0;
    end else begin
      if (capture_c) bdata <= adata;
      if (ack_tgl_c) b_ack <= ~b_ack;
      if (err_set_c) berr  <= 1'b1;
    end
  end

  assign bvalid = (state_q == VALID);

endmodule

// File: tb/tb_b_mcp_receive.sv
// Directed vector bench for b_mcp_receive at two synchronizer depths.
module tb_b_mcp_receive;

  typedef struct {
    logic       rst;
    logic       aen;
    logic [7:0] adata;
    logic       bload;
    logic       ev;
    logic [7:0] ed;
    logic       ea;
    logic       ee;
  } vec_t;

  logic       clk;
  logic       rst0, aen0, bload0, rst1, aen1, bload1;
  logic [7:0] adata0, adata1, bdata0, bdata1;
  logic       bvalid0, back0, berr0, bvalid1, back1, berr1;

  int total;
  int bad;
  vec_t tbl[$];

  b_mcp_receive #(.DW(8), .SYNC_STAGES(2)) u0 (
    .bclk(clk), .brst(rst0), .adata(adata0), .a_en(aen0), .bload(bload0),
    .bdata(bdata0), .bvalid(bvalid0), .b_ack(back0), .berr(berr0)
  );

  b_mcp_receive #(.DW(8), .SYNC_STAGES(3)) u1 (
    .bclk(clk), .brst(rst1), .adata(adata1), .a_en(aen1), .bload(bload1),
    .bdata(bdata1), .bvalid(bvalid1), .b_ack(back1), .berr(berr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic aen, input logic [7:0] ad,
                     input logic ld, input logic ev, input logic [7:0] ed,
                     input logic ea, input logic ee);
    vec_t v;
    v.rst = rst; v.aen = aen; v.adata = ad; v.bload = ld;
    v.ev = ev; v.ed = ed; v.ea = ea; v.ee = ee;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 ns after the following rising edge
  task automatic run_vec(input vec_t v, input int idx, input bit which);
    @(negedge clk);
    if (which == 1'b0) begin
      rst0 = v.rst; aen0 = v.aen; adata0 = v.adata; bload0 = v.bload;
    end else begin
      rst1 = v.rst; aen1 = v.aen; adata1 = v.adata; bload1 = v.bload;
    end
    @(posedge clk);
    #1;
    if (which == 1'b0) begin
      check("bvalid", idx, 8'(bvalid0), 8'(v.ev));
      check("bdata",  idx, bdata0,      v.ed);
      check("b_ack",  idx, 8'(back0),   8'(v.ea));
      check("berr",   idx, 8'(berr0),   8'(v.ee));
    end else begin
      check("s3_bvalid", idx, 8'(bvalid1), 8'(v.ev));
      check("s3_bdata",  idx, bdata1,      v.ed);
      check("s3_b_ack",  idx, 8'(back1),   8'(v.ea));
      check("s3_berr",   idx, 8'(berr1),   8'(v.ee));
    end
  endtask

  task automatic hand(input bit which, input int idx, input logic rst,
                      input logic aen, input logic [7:0] ad, input logic ld,
                      input logic ev, input logic [7:0] ed, input logic ea,
                      input logic ee);
    vec_t v;
    v.rst = rst; v.aen = aen; v.adata = ad; v.bload = ld;
    v.ev = ev; v.ed = ed; v.ea = ea; v.ee = ee;
    run_vec(v, idx, which);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst0 = 1'b1; aen0 = 1'b0; adata0 = 8'h00; bload0 = 1'b0;
    rst1 = 1'b1; aen1 = 1'b0; adata1 = 8'h00; bload1 = 1'b0;

    // reset, then quiet
    for (int i = 0; i < 3; i++)  add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    // single transfer, valid after E3, load at E5
    add(0, 1, 8'hA5, 0, 0, 8'h00, 0, 0);
    add(0, 1, 8'hA5, 0, 0, 8'h00, 0, 0);
    add(0, 1, 8'hA5, 0, 1, 8'hA5, 0, 0);
    add(0, 1, 8'hA5, 0, 1, 8'hA5, 0, 0);
    add(0, 1, 8'hA5, 1, 0, 8'hA5, 1, 0);
    add(0, 1, 8'hA5, 0, 0, 8'hA5, 1, 0);
    // joint reset with a_en back to 0, then back-to-back words
    add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    add(0, 1, 8'h3C, 0, 0, 8'h00, 0, 0);
    add(0, 1, 8'h3C, 0, 0, 8'h00, 0, 0);
    add(0, 1, 8'h3C, 0, 1, 8'h3C, 0, 0);
    add(0, 1, 8'h3C, 1, 0, 8'h3C, 1, 0);
    add(0, 0, 8'hC3, 0, 0, 8'h3C, 1, 0);
    add(0, 0, 8'hC3, 0, 0, 8'h3C, 1, 0);
    add(0, 0, 8'hC3, 0, 1, 8'hC3, 1, 0);
    add(0, 0, 8'hC3, 1, 0, 8'hC3, 0, 0);
    // consumer stall with adata moving underneath
    add(0, 1, 8'h5A, 0, 0, 8'hC3, 0, 0);
    add(0, 1, 8'h5A, 0, 0, 8'hC3, 0, 0);
    add(0, 1, 8'h5A, 0, 1, 8'h5A, 0, 0);
    for (int i = 0; i < 20; i++) add(0, 1, 8'hFF, 0, 1, 8'h5A, 0, 0);
    add(0, 1, 8'hFF, 1, 0, 8'h5A, 1, 0);
    // violation: second toggle before load
    add(0, 0, 8'h11, 0, 0, 8'h5A, 1, 0);
    add(0, 0, 8'h11, 0, 0, 8'h5A, 1, 0);
    add(0, 0, 8'h11, 0, 1, 8'h11, 1, 0);
    add(0, 1, 8'h22, 0, 1, 8'h11, 1, 0);
    add(0, 1, 8'h22, 0, 1, 8'h11, 1, 0);
    add(0, 1, 8'h22, 0, 1, 8'h11, 1, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 8'h22, 0, 1, 8'h11, 1, 1);
    add(0, 1, 8'h22, 1, 0, 8'h11, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 8'h22, 0, 0, 8'h11, 0, 1);
    // bload held in IDLE changes nothing
    for (int i = 0; i < 5; i++) add(0, 1, 8'h22, 1, 0, 8'h11, 0, 1);

    foreach (tbl[i]) run_vec(tbl[i], i, 1'b0);

    // pulse and load on the same edge: load honoured, word dropped, berr set
    hand(0, 100, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    hand(0, 101, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    hand(0, 102, 0, 1, 8'h44, 0, 0, 8'h00, 0, 0);
    hand(0, 103, 0, 1, 8'h44, 0, 0, 8'h00, 0, 0);
    hand(0, 104, 0, 1, 8'h44, 0, 1, 8'h44, 0, 0);
    hand(0, 105, 0, 0, 8'h55, 0, 1, 8'h44, 0, 0);
    hand(0, 106, 0, 0, 8'h55, 0, 1, 8'h44, 0, 0);
    hand(0, 107, 0, 0, 8'h55, 1, 0, 8'h44, 1, 1);
    for (int i = 0; i < 3; i++) hand(0, 108 + i, 0, 0, 8'h55, 0, 0, 8'h44, 1, 1);

    // three-stage synchronizer: valid only after E4
    hand(1, 200, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    hand(1, 201, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    hand(1, 202, 0, 1, 8'hA5, 0, 0, 8'h00, 0, 0);
    hand(1, 203, 0, 1, 8'hA5, 0, 0, 8'h00, 0, 0);
    hand(1, 204, 0, 1, 8'hA5, 0, 0, 8'h00, 0, 0);
    hand(1, 205, 0, 1, 8'hA5, 0, 1, 8'hA5, 0, 0);
    hand(1, 206, 0, 1, 8'hA5, 0, 1, 8'hA5, 0, 0);
    hand(1, 207, 0, 1, 8'hA5, 1, 0, 8'hA5, 1, 0);
    hand(1, 208, 0, 1, 8'hA5, 0, 0, 8'hA5, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/b_mcp_receive.md
Name: b_mcp_receive

Overview:
Receive end of the multi-cycle-path (MCP) CDC formulation, living in the b clock domain. The send side holds a data word stable and toggles an enable level. This block:
- synchronizes that toggle and turns it into a one-cycle pulse;
- captures the quasi-static data word and presents it with a valid/load handshake to the local consumer;
- returns a toggle acknowledge to the sender once the consumer has taken the word.

The returned acknowledge is what lets the sender's ready FSM issue the next word.

Parameters:
DW, 8, data word width; must be >= 1.
SYNC_STAGES, 2, flops in the a_en synchronizer chain; must be >= 2.

Ports:
bclk  input  1  b-domain clock.
brst  input  1  synchronous active-high reset.
adata  input  DW  data word from the sender. Launched in the a domain and held stable from its a_en toggle until the sender sees b_ack.
a_en  input  1  toggle enable from the sender (asynchronous to bclk). Each level change means one new word.
bload  input  1  consumer accepts the current word; only meaningful while bvalid=1.
bdata  output  DW  captured word; registered.
bvalid  output  1  bdata holds an unconsumed word.
b_ack  output  1  toggle acknowledge to the sender, which synchronizes it into its aq2_ack.
berr  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (brst=1 at a bclk edge): the following all go to 0:
  - the synchronizer flops and the pulse-gen delay flop;
  - the FSM (enters IDLE);
  - bdata, bvalid, b_ack, berr.
- Reset is synchronous only; outputs do not change before the bclk edge.
- Both MCP ends must be reset together, with the sender's a_en reset to 0. Under that condition no spurious pulse is generated after release.
- Synchronizer: bq[0] <= a_en, bq[i] <= bq[i-1]. The last stage feeds the pulse generator.
- Pulse generator: bq_d <= bq[SYNC_STAGES-1]; bpulse = bq[SYNC_STAGES-1] ^ bq_d. This gives one bclk-cycle pulse per a_en edge, in either direction.
- FSM, 2 states, bvalid = (state == VALID):
  - IDLE, bpulse=1 -> VALID. At the same edge bdata <= adata.
  - IDLE, bpulse=0 -> stay. bload is ignored in IDLE.
  - VALID, bload=1 -> IDLE. At the same edge b_ack <= ~b_ack.
  - VALID, bload=0 -> stay. bdata and b_ack are held for any stall length.
- Latency: say a_en toggles and is first sampled at edge E1. Then:
  - bpulse is high in the cycle after E(SYNC_STAGES);
  - bvalid=1 and bdata is valid after E(SYNC_STAGES+1);
  - with SYNC_STAGES=2, that is 3 edges.
- Load latency: bload sampled high with bvalid=1 at edge L -> bvalid=0 and b_ack toggled after L. A new word is then possible on the next pulse.
- b_ack changes exactly once per consumed word and never changes in IDLE.
- Violation: bpulse=1 while in VALID (the sender toggled again before its ack), including the cycle where bload=1 at the same edge.
  - berr <= 1, sticky until reset.
  - The extra pulse is dropped: no capture, no extra ack.
  - Any bload on that edge is still honoured normally.
- bdata is never overwritten while in VALID.
- No combinational path from any input to any output.

Decomposition:
- Package mcp_pkg holds:
  - typedef enum logic {IDLE, VALID} mcp_rx_state_t;
  - localparam MCP_DEF_SYNC_STAGES = 2;
  - localparam MCP_DEF_DW = 8.
- One sub-module, b_sync_pulse. It contains the SYNC_STAGES-deep synchronizer plus the edge-detect delay flop. Ports: bclk, brst, d (a_en), pulse (bpulse), q (synchronized level). Parameter: SYNC_STAGES.
- FSM and data/ack registers sit in b_mcp_receive.

Test Plan:
1. Reset: a_en=0, brst=1 for 3 cycles, then released with no activity for 10 cycles -> bvalid=0, bdata=0x00, b_ack=0, berr=0 throughout.
2. Single transfer: adata=0xA5, a_en 0->1 first sampled at edge E1 -> bvalid=1 and bdata=0xA5 after E3. bload=1 at E5 -> bvalid=0 and b_ack 0->1 after E5.
3. Back-to-back: 0x3C with a_en 0->1 -> load -> ack. Then 0xC3 with a_en 1->0 after the ack -> second word captured as 0xC3; b_ack returns 1->0 after the second load; berr=0.
4. Consumer stall: word 0x5A valid, bload=0 for 20 cycles while adata changes to 0xFF -> bdata stays 0x5A, bvalid=1, b_ack unchanged. Load then completes normally.
5. Violation: word 0x11 valid, a_en toggles again with adata=0x22 before bload -> berr=1 and sticky, bdata stays 0x11. One bload yields exactly one b_ack toggle, and the FSM returns to IDLE.
6. IDLE bload plus depth: bload=1 for 5 cycles in IDLE -> no output change. Rerun scenario 2 with SYNC_STAGES=3 -> bvalid rises after E4.
